// File: rtl/cipher_frame_tx.sv
// cipher_frame_tx: queues encrypter output blocks and sends each one as a sync/data/checksum byte frame.
// Define CIPHER_TX_KEY_EN to store the key with each block and append it to the frame.
module cipher_frame_tx #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_status,
    input  logic [0:63]       cipher_in,
    input  logic [0:63]       key_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);
`ifdef CIPHER_TX_KEY_EN
    localparam int         EW   = 128;
    localparam logic [3:0] LAST = 4'd15;
    logic [0:EW-1] entry;
    assign entry = {cipher_in, key_in};
`else
    localparam int         EW   = 64;
    localparam logic [3:0] LAST = 4'd7;
    logic [0:EW-1] entry;
    logic          unused_key;
    assign entry      = cipher_in;
    assign unused_key = ^key_in;
`endif

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

    state_t            state;
    logic [0:EW-1]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              status_q;
    logic [3:0]        byte_idx, nxt_idx;
    logic [7:0]        csum, csum_nxt;
    logic [0:EW-1]     head, head_sh;
    logic              hs, push, pop, full, wr_en;

    assign hs       = tx_valid && tx_ready;
    assign push     = enc_status && !status_q;
    assign full     = fifo_count == (ADDR_W+1)'(DEPTH);
    assign pop      = hs && state == CSUM;
    // a full FIFO still accepts a push when the head is retired on the same edge
    assign wr_en    = push && (!full || pop);
    assign head     = mem[rd_ptr];
    assign nxt_idx  = byte_idx + 4'd1;
    assign head_sh  = head << {nxt_idx, 3'b000};
    assign csum_nxt = csum ^ tx_data;
    assign busy     = state != IDLE;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            state      <= IDLE;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            byte_idx   <= 4'd0;
            csum       <= 8'h00;
        end else begin
            status_q   <= enc_status;
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push && full && !pop) overflow <= 1'b1;
            fifo_count <= fifo_count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
            case (state)
                IDLE: if (fifo_count != '0) begin
                    state    <= SYNC;
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                end
                SYNC: if (hs) begin
                    state    <= DATA;
                    byte_idx <= 4'd0;
                    csum     <= 8'h00;
                    tx_data  <= head[0:7];
                end
                DATA: if (hs) begin
                    csum <= csum_nxt;
                    if (byte_idx == LAST) begin
                        state   <= CSUM;
                        tx_data <= csum_nxt;
                    end else begin
                        byte_idx <= nxt_idx;
                        tx_data  <= head_sh[0:7];
                    end
                end
                CSUM: if (hs) begin
                    if (fifo_count > (ADDR_W+1)'(1)) begin
                        state   <= SYNC;
                        tx_data <= SYNC_BYTE;
                    end else begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_frame_tx.sv
// tb_cipher_frame_tx: scoreboard bench for cipher_frame_tx; expected frames are built from each issued block.
module tb_cipher_frame_tx;
`ifdef CIPHER_TX_KEY_EN
    localparam int FL = 18;
`else
    localparam int FL = 10;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0, enc_status = 1'b0, tx_ready = 1'b0;
    logic [63:0] cipher = '0, key = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, overflow;
    logic [2:0]  fifo_count;

    cipher_frame_tx #(.DEPTH(DEPTH), .ADDR_W(2), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .enc_status(enc_status), .cipher_in(cipher), .key_in(key),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_err = 0;
    logic [7:0] exp_q[$];
    bit         rnd_rdy = 0, tog = 0, gap_chk = 0, prev_stall = 0;
    logic [7:0] prev_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a frame is the sync byte, the block bytes MSB first, then their XOR
    function automatic void add_frame(input logic [63:0] c, input logic [63:0] k);
        logic [7:0] s = 8'h00, b;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            b = 8'(c >> (56 - 8 * i));
            exp_q.push_back(b);
            s ^= b;
        end
`ifdef CIPHER_TX_KEY_EN
        for (int i = 0; i < 8; i++) begin
            b = 8'(k >> (56 - 8 * i));
            exp_q.push_back(b);
            s ^= b;
        end
`else
        if (k === 64'hx) s = s;
`endif
        exp_q.push_back(s);
    endfunction

    function automatic int outstanding();
        return (exp_q.size() + FL - 1) / FL;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) tx_ready = ($urandom_range(0, 3) != 0);
        else if (tog) tx_ready = !tx_ready;
    endtask

    task automatic pulse(input logic [63:0] c, input logic [63:0] k, input int hi);
        cipher = c;
        key = k;
        enc_status = 1'b1;
        if (outstanding() < DEPTH) add_frame(c, k);
        repeat (hi) tick();
        enc_status = 1'b0;
        tick();
        check("count_model", fifo_count, outstanding());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d bytes left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_size(input int sz, input int budget);
        int n = 0;
        while (exp_q.size() > sz && n < budget) begin
            tick();
            n++;
        end
        check("wait_size", exp_q.size(), sz);
    endtask

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_d);
            end
            if (gap_chk && exp_q.size() != 0) check("no_gap", tx_valid, 1);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else check("byte", tx_data, exp_q.pop_front());
            end
            prev_stall = tx_valid && !tx_ready;
            prev_d = tx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] c;
        #12;
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single frame with latency
        tx_ready = 1'b1;
        cipher = 64'h1122334455667788;
        key = 64'h0102030405060708;
        enc_status = 1'b1;
        add_frame(cipher, key);
        tick();
        enc_status = 1'b0;
        check("lat_edge_n", tx_valid, 0);
        check("lat_count", fifo_count, 1);
        tick();
        check("lat_edge_n1", tx_valid, 1);
        check("lat_busy", busy, 1);
        drain(100);
        check("single_busy", busy, 0);
        check("single_valid", tx_valid, 0);
        check("single_count", fifo_count, 0);

        // back-pressure
        tog = 1;
        pulse(64'h1122334455667788, 64'h0102030405060708, 1);
        drain(200);
        tog = 0;
        tx_ready = 1'b1;
        tick();

        // random traffic
        rnd_rdy = 1;
        for (int b = 0; b < 20; b++) begin
            int n = 0;
            while (outstanding() >= DEPTH && n < 500) begin
                tick();
                n++;
            end
            repeat ($urandom_range(0, 3)) tick();
            pulse({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 4));
        end
        drain(3000);
        rnd_rdy = 0;
        tx_ready = 1'b1;
        tick();
        check("rand_ovf", overflow, 0);
        check("rand_count", fifo_count, 0);

        // push and pop on the same edge while full
        tx_ready = 1'b0;
        for (int b = 0; b < 4; b++) pulse({$urandom, $urandom}, {$urandom, $urandom}, 1);
        check("full_count", fifo_count, 4);
        tx_ready = 1'b1;
        wait_size(3 * FL + 1, 200);
        check("pre_simul_count", fifo_count, 4);
        c = {$urandom, $urandom};
        cipher = c;
        key = ~c;
        enc_status = 1'b1;
        add_frame(c, ~c);
        tick();
        enc_status = 1'b0;
        check("simul_count", fifo_count, 4);
        check("simul_ovf", overflow, 0);
        tick();
        drain(500);

        // level hold then overflow
        tx_ready = 1'b0;
        pulse(64'hA0A1A2A3A4A5A6A7, 64'h1, 10);
        check("hold_count", fifo_count, 1);
        for (int b = 0; b < 5; b++) pulse(64'hB000000000000000 + 64'(b), 64'(b), 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        gap_chk = 1;
        tx_ready = 1'b1;
        drain(500);
        gap_chk = 0;
        check("ovf_sticky", overflow, 1);
        check("ovf_idle", busy, 0);

        // reset mid-frame
        pulse(64'hDEADBEEFCAFEF00D, 64'h5, 1);
        wait_size(FL - 4, 50);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", tx_valid, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", overflow, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        pulse(64'h0, 64'h0, 1);
        drain(100);
        check("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
